// File: rtl/scan_session_scheduler.sv
// Logic-BIST session sequencer: walks the shared LFSR/MISR across each scan chain per pattern,
// captures, unloads the final responses and compares the MISR against a golden signature.
module scan_session_scheduler #(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned LEN_W      = 9,
  parameter int unsigned PAT_W      = 12,
  parameter int unsigned SIG_W      = 16,
  localparam int unsigned CW        = $clog2(NUM_CHAINS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_CHAINS*LEN_W-1:0] chain_len,
  input  logic [PAT_W-1:0]            num_patterns,
  input  logic [SIG_W-1:0]            golden_sig,
  input  logic [SIG_W-1:0]            misr_sig,
  output logic                        bist_init,
  output logic                        lfsr_en,
  output logic                        misr_en,
  output logic [CW-1:0]               chain_sel,
  output logic [NUM_CHAINS-1:0]       chain_se,
  output logic                        capture,
  output logic [PAT_W-1:0]            pat_cnt,
  output logic                        busy,
  output logic                        done,
  output logic                        pass
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StShift,
    StCapture,
    StUnload,
    StCompare
  } state_e;

  localparam logic [CW-1:0] LastChain = CW'(NUM_CHAINS - 1);

  state_e                      state_q, state_d;
  logic [CW-1:0]               chain_q, chain_d;
  logic [LEN_W-1:0]            bit_q, bit_d;
  logic [PAT_W-1:0]            pat_cnt_q, pat_cnt_d;
  logic [NUM_CHAINS*LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0]            npat_q, npat_d;
  logic [SIG_W-1:0]            golden_q, golden_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic [LEN_W-1:0]            cur_len;

  always_comb begin
    cur_len = '0;
    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
      if (chain_q == CW'(c)) cur_len = len_q[c*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    chain_d   = chain_q;
    bit_d     = bit_q;
    pat_cnt_d = pat_cnt_q;
    len_d     = len_q;
    npat_d    = npat_q;
    golden_d  = golden_q;
    done_d    = done_q;
    pass_d    = pass_q;

    if (abort && (state_q != StIdle)) begin
      // Abort wins over everything except rst; pat_cnt is left as-is for debug.
      state_d = StIdle;
      chain_d = '0;
      bit_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (num_patterns != '0)) begin
            state_d   = StInit;
            len_d     = chain_len;
            npat_d    = num_patterns;
            golden_d  = golden_sig;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            pat_cnt_d = '0;
          end
        end
        StInit: begin
          state_d = StShift;
          chain_d = '0;
          bit_d   = '0;
        end
        StShift, StUnload: begin
          // Zero-length chains still burn one skip cycle so S counts max(len,1).
          if ((cur_len == '0) || (bit_q == cur_len - LEN_W'(1))) begin
            bit_d = '0;
            if (chain_q == LastChain) begin
              chain_d = '0;
              state_d = (state_q == StShift) ? StCapture : StCompare;
            end else begin
              chain_d = chain_q + CW'(1);
            end
          end else begin
            bit_d = bit_q + LEN_W'(1);
          end
        end
        StCapture: begin
          pat_cnt_d = pat_cnt_q + PAT_W'(1);
          chain_d   = '0;
          bit_d     = '0;
          state_d   = (pat_cnt_d < npat_q) ? StShift : StUnload;
        end
        StCompare: begin
          pass_d  = (misr_sig == golden_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      chain_q   <= '0;
      bit_q     <= '0;
      pat_cnt_q <= '0;
      len_q     <= '0;
      npat_q    <= '0;
      golden_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      bit_q     <= bit_d;
      pat_cnt_q <= pat_cnt_d;
      len_q     <= len_d;
      npat_q    <= npat_d;
      golden_q  <= golden_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    bist_init = 1'b0;
    lfsr_en   = 1'b0;
    misr_en   = 1'b0;
    chain_sel = '0;
    chain_se  = '0;
    capture   = 1'b0;
    unique case (state_q)
      StInit:    bist_init = 1'b1;
      StShift: begin
        chain_sel = chain_q;
        if (cur_len != '0) begin
          chain_se = {{(NUM_CHAINS-1){1'b0}}, 1'b1} << chain_q;
          lfsr_en  = 1'b1;
          // First pattern has no prior responses worth compacting.
          misr_en  = (pat_cnt_q != '0);
        end
      end
      StUnload: begin
        chain_sel = chain_q;
        if (cur_len != '0) begin
          chain_se = {{(NUM_CHAINS-1){1'b0}}, 1'b1} << chain_q;
          misr_en  = 1'b1;
        end
      end
      StCapture: capture = 1'b1;
      default: ;
    endcase
  end

  assign pat_cnt = pat_cnt_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign pass    = pass_q;

endmodule
